// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera pixel capture block.
//   - Default active-area geometry (640x480, RGB565).
//   - Output coordinate widths and internal counter widths (one extra bit so a
//     counter can hold the full H_RES / V_RES value).
//   - Capture FSM state encoding.
package cam_capture_pkg;

  localparam int unsigned HResDef = 640;
  localparam int unsigned VResDef = 480;

  // Output coordinate widths (pix_x_o / pix_y_o).
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;

  // Internal counter widths.
  localparam int unsigned XCW = XW + 1;
  localparam int unsigned YCW = YW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitBlank,
    StWaitActive,
    StActive
  } cap_state_e;

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Pixel output stream of the camera capture block.
//   pix_valid : one-cycle strobe, pixel present on pix_data
//   pix_data  : RGB565 pixel, first camera byte in [15:8]
//   pix_x     : column of the pixel
//   pix_y     : line of the pixel
//   sof       : first pixel of frame    (qualified by pix_valid)
//   eol       : last pixel of line      (qualified by pix_valid)
//   eof       : last pixel of frame     (qualified by pix_valid)
// Modports: master = capture block (drives), slave = pixel consumer.
interface cam_pixel_capture_if;
  import cam_capture_pkg::*;

  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          sof;
  logic          eol;
  logic          eof;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, sof, eol, eof
  );

  modport slave (
    input pix_valid, pix_data, pix_x, pix_y, sof, eol, eof
  );

endinterface

// File: rtl/rgb565_byte_packer.sv
// Pairs consecutive camera bytes into an RGB565 pixel.
// Ports:
//   clk_i, rst_i   : pixel clock, asynchronous active-high reset
//   byte_valid_i   : byte_i is an accepted active byte this cycle
//   phase_i        : 0 = first (high) byte of a pixel, 1 = second (low) byte
//   byte_i         : camera byte
//   pix_stb_o      : combinational strobe, pixel completes this cycle
//   pix_data_o     : {held first byte, byte_i}
module rgb565_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic        phase_i,
  input  logic [7:0]  byte_i,
  output logic        pix_stb_o,
  output logic [15:0] pix_data_o
);

  logic [7:0] hi_q, hi_d;

  always_comb begin
    hi_d = hi_q;
    if (byte_valid_i && !phase_i) begin
      hi_d = byte_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= 8'h00;
    end else begin
      hi_q <= hi_d;
    end
  end

  assign pix_stb_o  = byte_valid_i & phase_i;
  assign pix_data_o = {hi_q, byte_i};

endmodule

// File: rtl/cam_pixel_capture.sv
// Camera (DVP-style) pixel capture: turns VSYNC/HREF/D[7:0] byte traffic into
// RGB565 pixel strobes with coordinates and frame/line markers.
// Ports:
//   clk_i, rst_i       : camera pixel clock, asynchronous active-high reset
//   capture_en_i       : capture frames while high (frame in flight always completes)
//   vsync_i, href_i    : camera sync inputs
//   data_i             : camera byte bus
//   pix_if             : pixel output stream (master modport)
//   busy_o             : in ACTIVE state
//   line_err_o         : one-cycle pulse on a malformed line or aborted frame
// Optional feature, enabled by defining CAM_CAPTURE_STATS_EN:
//   frame_cnt_o        : completed frames, wraps
//   err_cnt_o          : line_err_o pulses, saturates at 0xFF
module cam_pixel_capture
  import cam_capture_pkg::*;
#(
  parameter int unsigned H_RES     = HResDef,
  parameter int unsigned V_RES     = VResDef,
  parameter bit          VSYNC_POL = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       capture_en_i,
  input  logic                       vsync_i,
  input  logic                       href_i,
  input  logic [7:0]                 data_i,
  cam_pixel_capture_if.master        pix_if,
  output logic                       busy_o,
  output logic                       line_err_o
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [15:0]                frame_cnt_o,
  output logic [7:0]                 err_cnt_o
`endif
);

  localparam logic [XCW-1:0] HResC = XCW'(H_RES);
  localparam logic [XCW-1:0] HLast = XCW'(H_RES - 1);
  localparam logic [YCW-1:0] VResC = YCW'(V_RES);
  localparam logic [YCW-1:0] VLast = YCW'(V_RES - 1);

  // Input stage plus one-cycle-delayed copies for edge detection.
  logic       vsync_q, href_q, href_prev_q, blank_prev_q;
  logic [7:0] data_q;
  logic       blank;

  assign blank = (vsync_q == VSYNC_POL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      href_prev_q  <= 1'b0;
      blank_prev_q <= 1'b0;
    end else begin
      vsync_q      <= vsync_i;
      href_q       <= href_i;
      data_q       <= data_i;
      href_prev_q  <= href_q;
      blank_prev_q <= blank;
    end
  end

  cap_state_e     state_q, state_d;
  logic [XCW-1:0] x_q, x_d;
  logic [YCW-1:0] y_q, y_d;
  logic           phase_q, phase_d;
  logic           ovf_q, ovf_d;

  logic          pix_valid_q, pix_valid_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic          sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic          line_err_q, line_err_d;

  // Lines past V_RES (only reachable after a short last line) produce nothing.
  logic line_live;
  logic byte_en;
  logic pk_stb;
  logic [15:0] pk_data;

  assign line_live = (y_q < VResC);
  assign byte_en   = (state_q == StActive) && !blank && line_live && href_q && (x_q < HResC);

  rgb565_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_valid_i (byte_en),
    .phase_i      (phase_q),
    .byte_i       (data_q),
    .pix_stb_o    (pk_stb),
    .pix_data_o   (pk_data)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = phase_q;
    ovf_d       = ovf_q;
    pix_valid_d = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    eof_d       = 1'b0;
    line_err_d  = 1'b0;
    // Data and coordinates hold the last pixel between strobes.
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;

    unique case (state_q)
      StIdle: begin
        if (capture_en_i) state_d = StWaitBlank;
      end
      // Only a blanking interval proves we are not joining mid-frame.
      StWaitBlank: begin
        if (!capture_en_i) state_d = StIdle;
        else if (blank)    state_d = StWaitActive;
      end
      StWaitActive: begin
        if (!capture_en_i) begin
          state_d = StIdle;
        end else if (blank_prev_q && !blank) begin
          state_d = StActive;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StActive: begin
        if (blank) begin
          // Frame ended before its last pixel.
          line_err_d = 1'b1;
          state_d    = capture_en_i ? StWaitActive : StIdle;
        end else if (line_live) begin
          if (href_q) begin
            if (x_q < HResC) begin
              phase_d = ~phase_q;
              if (pk_stb) begin
                pix_valid_d = 1'b1;
                pix_data_d  = pk_data;
                pix_x_d     = x_q[XW-1:0];
                pix_y_d     = y_q[YW-1:0];
                sof_d       = (x_q == '0) && (y_q == '0);
                eol_d       = (x_q == HLast);
                eof_d       = (x_q == HLast) && (y_q == VLast);
                x_d         = x_q + XCW'(1);
                if (eof_d) state_d = capture_en_i ? StWaitActive : StIdle;
              end
            end else begin
              ovf_d = 1'b1;
            end
          end else if (href_prev_q) begin
            // End of line: short, odd or overlong lines are all one error pulse.
            line_err_d = ovf_q || phase_q || (x_q != HResC);
            if (x_q != '0) y_d = y_q + YCW'(1);
            x_d     = '0;
            phase_d = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 1'b0;
      ovf_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= 16'h0000;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      line_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      ovf_q       <= ovf_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      line_err_q  <= line_err_d;
    end
  end

  assign pix_if.pix_valid = pix_valid_q;
  assign pix_if.pix_data  = pix_data_q;
  assign pix_if.pix_x     = pix_x_q;
  assign pix_if.pix_y     = pix_y_q;
  assign pix_if.sof       = sof_q;
  assign pix_if.eol       = eol_q;
  assign pix_if.eof       = eof_q;
  assign busy_o           = (state_q == StActive);
  assign line_err_o       = line_err_q;

`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (eof_q) frame_cnt_d = frame_cnt_q + 16'd1;
    if (line_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= 16'h0000;
      err_cnt_q   <= 8'h00;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture with a 4x2 active area.
// Stimulus pushes expected pixels (data, coordinates, markers, arrival cycle);
// a monitor pops and compares on every pixel strobe.
module tb_cam_pixel_capture;

  localparam int unsigned HR = 4;
  localparam int unsigned VR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       capture_en;
  logic       vsync;
  logic       href;
  logic [7:0] data;
  logic       busy;
  logic       line_err;
`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  cam_pixel_capture_if pix_if ();

  cam_pixel_capture #(
    .H_RES     (HR),
    .V_RES     (VR),
    .VSYNC_POL (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .capture_en_i (capture_en),
    .vsync_i      (vsync),
    .href_i       (href),
    .data_i       (data),
    .pix_if       (pix_if),
    .busy_o       (busy),
    .line_err_o   (line_err)
`ifdef CAM_CAPTURE_STATS_EN
    ,
    .frame_cnt_o  (frame_cnt),
    .err_cnt_o    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sof;
    logic        eol;
    logic        eof;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          err_seen   = 0;
  logic [31:0] cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample one time unit after the active edge.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (line_err) err_seen++;
      if (pix_if.pix_valid) begin
        got = '{data: pix_if.pix_data, x: pix_if.pix_x, y: pix_if.pix_y, sof: pix_if.sof,
                eol: pix_if.eol, eof: pix_if.eof, cyc: cyc};
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pixel: got data=%h x=%0d y=%0d at cyc %0d, required no strobe",
                   got.data, got.x, got.y, got.cyc);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            mismatched++;
            $display("FAIL pixel: got data=%h x=%0d y=%0d sof=%b eol=%b eof=%b cyc=%0d, required data=%h x=%0d y=%0d sof=%b eol=%b eof=%b cyc=%0d",
                     got.data, got.x, got.y, got.sof, got.eol, got.eof, got.cyc,
                     e.data, e.x, e.y, e.sof, e.eol, e.eof, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic vblank();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Drives nb bytes first, first+1, ... on one HREF line; when exp_on, the
  // pixels the line must produce (at most HR) are pushed, due two clocks after
  // their second byte is presented.
  task automatic send_line(input int nb, input logic [7:0] first, input int line, input bit exp_on);
    logic [7:0] b;
    logic [7:0] hi;
    exp_t e;
    hi = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = first + 8'(i);
      if (i % 2 == 0) begin
        hi = b;
      end else if (exp_on && (i / 2 < HR)) begin
        e.data = {hi, b};
        e.x    = 10'(i / 2);
        e.y    = 9'(line);
        e.sof  = (i / 2 == 0) && (line == 0);
        e.eol  = (i / 2 == HR - 1);
        e.eof  = (i / 2 == HR - 1) && (line == VR - 1);
        e.cyc  = cyc + 2;
        q.push_back(e);
      end
      href = 1'b1;
      data = b;
      @(negedge clk);
    end
    href = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, q.size(), 0);
    q.delete();
  endtask

  task automatic good_frame(input logic [7:0] first);
    vblank();
    send_line(8, first, 0, 1'b1);
    send_line(8, first + 8'd8, 1, 1'b1);
  endtask

  initial begin
    exp_t e;
    rst        = 1'b1;
    capture_en = 1'b0;
    vsync      = 1'b0;
    href       = 1'b0;
    data       = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pix_valid", pix_if.pix_valid, 0);
    check("rst_pix_data", pix_if.pix_data, 0);
    check("rst_pix_xy", {pix_if.pix_x, pix_if.pix_y}, 0);
    check("rst_flags", {pix_if.sof, pix_if.eol, pix_if.eof}, 0);
    check("rst_busy", busy, 0);
    check("rst_line_err", line_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 4x2 frame, bytes 0x01..0x10
    capture_en = 1'b1;
    good_frame(8'h01);
    drain("t1_drain");
    check("t1_last_data", pix_if.pix_data, 32'h0F10);
    check("t1_last_y", pix_if.pix_y, 1);
    check("t1_busy_after_eof", busy, 0);
    check("t1_err", err_seen, 0);

    // Enable raised while VSYNC already active: nothing until a full frame
    capture_en = 1'b0;
    repeat (2) @(negedge clk);
    send_line(8, 8'h21, 0, 1'b0);
    capture_en = 1'b1;
    send_line(8, 8'h29, 1, 1'b0);
    check("t2_busy_midframe", busy, 0);
    good_frame(8'h31);
    drain("t2_drain");
    check("t2_err", err_seen, 0);

    // 7-byte line: 3 pixels, one error, next line restarts at x=0
    vblank();
    send_line(7, 8'h41, 0, 1'b1);
    send_line(8, 8'h51, 1, 1'b1);
    drain("t3_drain");
    check("t3_err", err_seen, 1);

    // 10-byte line: 4 pixels, surplus dropped, one error
    vblank();
    send_line(10, 8'h61, 0, 1'b1);
    send_line(8, 8'h71, 1, 1'b1);
    drain("t4_drain");
    check("t4_err", err_seen, 2);

    // VSYNC back to blanking after line 0: abort, then a fresh frame
    vblank();
    send_line(8, 8'h81, 0, 1'b1);
    check("t5_busy_before_abort", busy, 1);
    good_frame(8'h91);
    drain("t5_drain");
    check("t5_err", err_seen, 3);

    // Reset between the bytes of a pixel
    vblank();
    href = 1'b1;
    data = 8'hA1;
    @(negedge clk);
    e = '{data: 16'hA1A2, x: 10'd0, y: 9'd0, sof: 1'b1, eol: 1'b0, eof: 1'b0, cyc: cyc + 2};
    q.push_back(e);
    data = 8'hA2;
    @(negedge clk);
    data = 8'hA3;
    @(negedge clk);
    check("t6_data_before_rst", pix_if.pix_data, 32'hA1A2);
    data = 8'hA4;
    rst  = 1'b1;
    #1;
    check("t6_rst_pix_valid", pix_if.pix_valid, 0);
    check("t6_rst_pix_data", pix_if.pix_data, 0);
    check("t6_rst_busy", busy, 0);
    @(negedge clk);
    href = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_busy_after_rst", busy, 0);
    check("t6_queue_empty", q.size(), 0);
    good_frame(8'hB1);
    drain("t6_recovery_drain");
    check("t6_err", err_seen, 3);

`ifdef CAM_CAPTURE_STATS_EN
    // Counters were cleared by the reset above; one frame since.
    good_frame(8'hC1);
    good_frame(8'hD1);
    drain("stats_drain");
    repeat (2) @(negedge clk);
    check("stats_frame_cnt", frame_cnt, 3);
    check("stats_err_cnt", err_cnt, 0);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    good_frame(8'hE1);
    drain("stats_wrap_drain");
    repeat (2) @(negedge clk);
    check("stats_frame_wrap", frame_cnt, 0);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cam_pixel_capture.md
CAM_PIXEL_CAPTURE -- requirements
Module: cam_pixel_capture

Interface
REQ-001 Parameter H_RES, 640, active pixels per line (RGB565, 2 bytes/pixel).
REQ-002 Parameter V_RES, 480, active lines per frame.
REQ-003 Parameter VSYNC_POL, 1, VSYNC level meaning vertical blanking (1 = high).
REQ-004 Port clk_i  in  1  camera pixel clock; sole clock, all logic on rising edge.
REQ-005 Port rst_i  in  1  asynchronous, active-high reset.
REQ-006 Port capture_en_i  in  1  high = capture frames; set by camera control once register init completes.
REQ-007 Port vsync_i  in  1  camera VSYNC.
REQ-008 Port href_i  in  1  camera HREF, high during active bytes.
REQ-009 Port data_i  in  8  camera data bus D[7:0].
REQ-010 Port pix_valid_o  out  1  one-cycle strobe, pixel on pix_data_o.
REQ-011 Port pix_data_o  out  16  RGB565 pixel, first byte in [15:8].
REQ-012 Port pix_x_o  out  10  column of current pixel; pix_y_o  out  9  line of current pixel.
REQ-013 Port sof_o / eol_o / eof_o  out  1 each  qualified by pix_valid_o: first pixel of frame / last pixel of line / last pixel of frame.
REQ-014 Port busy_o  out  1  high while in ACTIVE state.
REQ-015 Port line_err_o  out  1  one-cycle pulse on malformed line.

Function
REQ-016 vsync_i, href_i, data_i SHALL be registered once before use (input stage).
REQ-017 FSM states: IDLE, WAIT_BLANK, WAIT_ACTIVE, ACTIVE.
REQ-018 IDLE -> WAIT_BLANK when capture_en_i=1.
REQ-019 WAIT_BLANK -> WAIT_ACTIVE when registered VSYNC at blanking level; never enter mid-frame.
REQ-020 WAIT_ACTIVE -> ACTIVE on VSYNC blanking-to-active transition; x, y, byte phase cleared.
REQ-021 In ACTIVE, each registered byte with HREF=1 toggles byte phase; phase 0 byte held in [15:8], phase 1 byte completes pixel.
REQ-022 pix_valid_o SHALL assert on the cycle after the registered second byte (2 clocks after second byte at the pins).
REQ-023 pix_x_o increments per pixel, resets to 0 on HREF falling edge; pix_y_o increments on each HREF falling edge that ended a line of at least one pixel.
REQ-024 Bytes beyond H_RES pixels on a line SHALL be dropped, not output; line_err_o pulses once at HREF fall.
REQ-025 HREF fall with odd byte count or fewer than H_RES pixels SHALL pulse line_err_o; partial byte discarded.
REQ-026 eol_o asserts with pixel x=H_RES-1; eof_o additionally requires y=V_RES-1; then ACTIVE -> WAIT_ACTIVE (capture_en_i=1) or IDLE (capture_en_i=0).
REQ-027 Lines beyond V_RES in a frame SHALL be ignored without output.
REQ-028 VSYNC returning to blanking in ACTIVE before eof_o: abort frame, no eof_o, pulse line_err_o, go to WAIT_ACTIVE (or IDLE if capture_en_i=0).
REQ-029 capture_en_i falling mid-frame SHALL not truncate the current frame; block stops at its end.

Reset
REQ-030 rst_i asserted: state IDLE; all outputs 0; x, y, byte phase, input registers 0; mid-frame reset discards partial pixel with no strobe.

Configuration
REQ-031 Macro CAM_CAPTURE_STATS_EN defined: add output frame_cnt_o (16 bits, wraps at 0xFFFF -> 0, increments on eof_o) and err_cnt_o (8 bits, saturates at 0xFF, increments on line_err_o), both reset to 0.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 FSM state enum and default H_RES/V_RES constants SHALL live in shared package cam_capture_pkg.
REQ-034 Byte-to-RGB565 pairing SHALL be a sub-module rgb565_byte_packer (byte in, phase, pixel strobe out).

Verification
REQ-035 Reset then capture_en_i=1 with a 4x2 frame (H_RES=4, V_RES=2), bytes 0x01..0x10 -> 8 strobes, first 0x0102 with sof_o, last 0x0F10 with eof_o, pix_y_o=1.
REQ-036 capture_en_i raised while VSYNC active mid-frame -> no output until next full frame.
REQ-037 Line of 7 bytes (H_RES=4) -> 3 pixels, line_err_o one pulse, next line x restarts at 0.
REQ-038 VSYNC to blanking after line 0 of 2 -> no eof_o, line_err_o pulse, next frame starts with sof_o.
REQ-039 rst_i asserted between bytes of a pixel -> no strobe, outputs 0 same cycle, state IDLE.
REQ-040 With CAM_CAPTURE_STATS_EN, 3 good frames -> frame_cnt_o=3; frame_cnt_o preloaded to 0xFFFF + one frame -> 0.
